// File: rtl/fact_engine_if.sv
// fact_engine_if: request/response bundle for the iterative factorial unit.
// The master drives start/n and samples busy/done/result/ovf; the engine is the slave.
interface fact_engine_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, n,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, n,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/fact_engine.sv
// fact_engine: iterative n! unit with an internal IDLE/RUN/DONE sequencer.
// A job is accepted on start in IDLE or DONE. RUN multiplies the accumulator by
// an up-counter from 2 until the counter equals the latched operand. The result
// is published only on entry to DONE.
// Optional feature macro: FACT_OVF_EN (sticky overflow detection with
// saturation of the accumulator and result to all-ones). When it is undefined,
// ovf is constant 0 and result is n! mod 2^WIDTH.
module fact_engine #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fact_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_s;  // accumulator value after this RUN step

`ifdef FACT_OVF_EN
  logic [2*WIDTH-1:0] prod_s;
  logic               step_ovf_s;
  logic               ovf_q, ovf_d;          // sticky overflow of the running job
  logic               ovf_out_q, ovf_out_d;  // published with result

  assign prod_s = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, cnt_q};

  // One multiply step with overflow detection; once overflowed the product pins at all-ones.
  always_comb begin
    step_ovf_s = ovf_q;
    step_s     = prod_s[WIDTH-1:0];
    if (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}) begin
      step_ovf_s = 1'b1;
    end else begin
      step_ovf_s = ovf_q;
    end
    if (step_ovf_s) begin
      step_s = ALL_ONES;
    end else begin
      step_s = prod_s[WIDTH-1:0];
    end
  end

  assign bus.ovf = ovf_out_q;
`else
  // Modulo-2^WIDTH product: only the low half of the full product is kept.
  assign step_s  = acc_q * cnt_q;
  assign bus.ovf = 1'b0;
`endif

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
`ifdef FACT_OVF_EN
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          n_d   = bus.n;
          acc_d = ONE;
`ifdef FACT_OVF_EN
          ovf_d = 1'b0;
`endif
          if (bus.n <= ONE) begin
            // 0! and 1! complete immediately without entering RUN.
            state_d  = S_DONE;
            result_d = ONE;
`ifdef FACT_OVF_EN
            ovf_out_d = 1'b0;
`endif
          end else begin
            cnt_d   = TWO;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step_s;
        cnt_d = cnt_q + ONE;
`ifdef FACT_OVF_EN
        ovf_d = step_ovf_s;
`endif
        // Equality termination: cnt stops at n_q, so it never wraps within a job.
        if (cnt_q == n_q) begin
          state_d  = S_DONE;
          result_d = step_s;
`ifdef FACT_OVF_EN
          ovf_out_d = step_ovf_s;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= {WIDTH{1'b0}};
      cnt_q    <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef FACT_OVF_EN
  // Overflow flags: sticky per-job flag and the copy published with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
    end
  end
`endif

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: directed self-checking bench for fact_engine at WIDTH=8 and WIDTH=16.
// Expected values follow FACT_OVF_EN when it is defined for the build.
module tb_fact_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

`ifdef FACT_OVF_EN
  localparam logic [7:0]  EXP_N6_RES   = 8'd255;
  localparam logic        EXP_N6_OVF   = 1'b1;
  localparam logic [7:0]  EXP_N255_RES = 8'd255;
  localparam logic        EXP_N255_OVF = 1'b1;
  localparam logic [15:0] EXP_N9_RES   = 16'd65535;
  localparam logic        EXP_N9_OVF   = 1'b1;
`else
  localparam logic [7:0]  EXP_N6_RES   = 8'd208;     // 720 mod 256
  localparam logic        EXP_N6_OVF   = 1'b0;
  localparam logic [7:0]  EXP_N255_RES = 8'd0;       // 255! has many factors of 2
  localparam logic        EXP_N255_OVF = 1'b0;
  localparam logic [15:0] EXP_N9_RES   = 16'd35200;  // 362880 mod 65536
  localparam logic        EXP_N9_OVF   = 1'b0;
`endif

  fact_engine_if #(.WIDTH(8))  if8 ();
  fact_engine_if #(.WIDTH(16)) if16 ();

  fact_engine #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  fact_engine #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and wait (bounded) for done; lat counts cycles
  // after the accepting edge (1 = done in the first cycle), -1 on timeout.
  task automatic run_job(input bit wide, input logic [15:0] nv, output int lat,
                         output int busy_n, output logic [15:0] res, output logic ov);
    lat    = -1;
    busy_n = 0;
    res    = 16'd0;
    ov     = 1'b0;
    if (wide) begin
      if16.start = 1'b1;
      if16.n     = nv;
    end else begin
      if8.start = 1'b1;
      if8.n     = nv[7:0];
    end
    tick();
    if8.start  = 1'b0;
    if16.start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (wide) begin
        if (if16.busy) busy_n++;
        if (if16.done) begin
          lat = k;
          res = if16.result;
          ov  = if16.ovf;
          break;
        end
      end else begin
        if (if8.busy) busy_n++;
        if (if8.done) begin
          lat = k;
          res = {8'd0, if8.result};
          ov  = if8.ovf;
          break;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", if8.done); else pass_cnt++;
    total_cnt++; if (if8.result !== 8'd0) $display("FAIL reset_result: got %0d expected 0", if8.result); else pass_cnt++;
    total_cnt++; if (if8.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", if8.ovf); else pass_cnt++;
    total_cnt++; if (if16.result !== 16'd0) $display("FAIL reset_result16: got %0d expected 0", if16.result); else pass_cnt++;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_n5();
    int lat, bn;
    logic [15:0] res;
    logic ov;
    run_job(1'b0, 16'd5, lat, bn, res, ov);
    total_cnt++; if (lat !== 5) $display("FAIL n5_latency: got %0d expected 5", lat); else pass_cnt++;
    total_cnt++; if (bn !== 4) $display("FAIL n5_busy_cycles: got %0d expected 4", bn); else pass_cnt++;
    total_cnt++; if (res !== 16'd120) $display("FAIL n5_result: got %0d expected 120", res); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL n5_ovf: got %b expected 0", ov); else pass_cnt++;
    tick();
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL n5_done_pulse: got %b expected 0", if8.done); else pass_cnt++;
    total_cnt++; if (if8.result !== 8'd120) $display("FAIL n5_result_hold: got %0d expected 120", if8.result); else pass_cnt++;
  endtask

  task automatic test_small_n();
    int lat, bn;
    logic [15:0] res;
    logic ov;
    for (int v = 0; v <= 1; v++) begin
      run_job(1'b0, 16'(v), lat, bn, res, ov);
      total_cnt++; if (lat !== 1) $display("FAIL small_n%0d_latency: got %0d expected 1", v, lat); else pass_cnt++;
      total_cnt++; if (bn !== 0) $display("FAIL small_n%0d_busy: got %0d expected 0", v, bn); else pass_cnt++;
      total_cnt++; if (res !== 16'd1) $display("FAIL small_n%0d_result: got %0d expected 1", v, res); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_overflow();
    int lat, bn;
    logic [15:0] res;
    logic ov;
    run_job(1'b0, 16'd6, lat, bn, res, ov);
    total_cnt++; if (res !== {8'd0, EXP_N6_RES}) $display("FAIL n6_result: got %0d expected %0d", res, EXP_N6_RES); else pass_cnt++;
    total_cnt++; if (ov !== EXP_N6_OVF) $display("FAIL n6_ovf: got %b expected %b", ov, EXP_N6_OVF); else pass_cnt++;
    tick();
    run_job(1'b0, 16'd3, lat, bn, res, ov);
    total_cnt++; if (res !== 16'd6) $display("FAIL n3_after_ovf_result: got %0d expected 6", res); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL n3_after_ovf_ovf: got %b expected 0", ov); else pass_cnt++;
    tick();
    run_job(1'b0, 16'd255, lat, bn, res, ov);
    total_cnt++; if (lat !== 255) $display("FAIL n255_latency: got %0d expected 255", lat); else pass_cnt++;
    total_cnt++; if (res !== {8'd0, EXP_N255_RES}) $display("FAIL n255_result: got %0d expected %0d", res, EXP_N255_RES); else pass_cnt++;
    total_cnt++; if (ov !== EXP_N255_OVF) $display("FAIL n255_ovf: got %b expected %b", ov, EXP_N255_OVF); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat2;
    bit seen;
    // Job 1: n=4, with a spurious start and n changes while it runs.
    if8.start = 1'b1;
    if8.n     = 8'd4;
    tick();
    if8.start = 1'b0;
    if8.n     = 8'd9;
    tick();
    if8.start = 1'b1;
    if8.n     = 8'd7;
    tick();
    if8.start = 1'b0;
    if8.n     = 8'd2;
    tick();
    // Fourth cycle after the accepting edge: job 1 completes here.
    total_cnt++; if (if8.done !== 1'b1) $display("FAIL b2b_job1_done: got %b expected 1", if8.done); else pass_cnt++;
    total_cnt++; if (if8.result !== 8'd24) $display("FAIL b2b_job1_result: got %0d expected 24", if8.result); else pass_cnt++;
    // Accept job 2 in the DONE cycle.
    if8.start = 1'b1;
    if8.n     = 8'd3;
    tick();
    if8.start = 1'b0;
    if8.n     = 8'd170;
    total_cnt++; if (if8.busy !== 1'b1) $display("FAIL b2b_job2_busy: got %b expected 1", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.result !== 8'd24) $display("FAIL b2b_result_held: got %0d expected 24", if8.result); else pass_cnt++;
    lat2 = -1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen && if8.done) begin
        lat2 = k;
        seen = 1'b1;
        total_cnt++; if (if8.result !== 8'd6) $display("FAIL b2b_job2_result: got %0d expected 6", if8.result); else pass_cnt++;
      end
      if (!seen) tick();
    end
    total_cnt++; if (lat2 !== 3) $display("FAIL b2b_job2_latency: got %0d expected 3", lat2); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, bn;
    logic [15:0] res;
    logic ov;
    if8.start = 1'b1;
    if8.n     = 8'd5;
    tick();
    if8.start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", if8.done); else pass_cnt++;
    total_cnt++; if (if8.result !== 8'd0) $display("FAIL midrst_result: got %0d expected 0", if8.result); else pass_cnt++;
    total_cnt++; if (if8.ovf !== 1'b0) $display("FAIL midrst_ovf: got %b expected 0", if8.ovf); else pass_cnt++;
    #3 rst_n = 1'b1;
    tick();
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL midrst_no_completion: got %b expected 0", if8.done); else pass_cnt++;
    run_job(1'b0, 16'd3, lat, bn, res, ov);
    total_cnt++; if (lat !== 3) $display("FAIL postrst_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++; if (res !== 16'd6) $display("FAIL postrst_result: got %0d expected 6", res); else pass_cnt++;
    tick();
  endtask

  task automatic test_wide();
    int lat, bn;
    logic [15:0] res;
    logic ov;
    run_job(1'b1, 16'd8, lat, bn, res, ov);
    total_cnt++; if (lat !== 8) $display("FAIL w16_n8_latency: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++; if (res !== 16'd40320) $display("FAIL w16_n8_result: got %0d expected 40320", res); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL w16_n8_ovf: got %b expected 0", ov); else pass_cnt++;
    tick();
    run_job(1'b1, 16'd9, lat, bn, res, ov);
    total_cnt++; if (res !== EXP_N9_RES) $display("FAIL w16_n9_result: got %0d expected %0d", res, EXP_N9_RES); else pass_cnt++;
    total_cnt++; if (ov !== EXP_N9_OVF) $display("FAIL w16_n9_ovf: got %b expected %b", ov, EXP_N9_OVF); else pass_cnt++;
    tick();
  endtask

  initial begin
    if8.start  = 1'b0;
    if8.n      = 8'd0;
    if16.start = 1'b0;
    if16.n     = 16'd0;
    test_reset();
    test_n5();
    test_small_n();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fact_engine.md
# fact_engine

Self-contained, parametrised iterative factorial unit: control FSM, counter, multiplier and accumulator in one block. It replaces the separate datapath-plus-external-controller split with an internal sequencer and a start/busy/done handshake. It adds width generalisation and optional overflow detection with saturation. It sits behind any master that can drive a one-cycle `start` and sample `result` on `done`.

## Interface
- `WIDTH`, default 8: bit width of `n`, the counter, the accumulator and `result`.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: request; sampled only in IDLE or DONE.
- `n` input WIDTH: operand; sampled on the accepted `start` edge only.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; `result` and `ovf` are valid from this cycle on.
- `result` output WIDTH: registered n!; holds until the next completion.
- `ovf` output 1: n! exceeded 2^WIDTH−1. Tied 0 unless `FACT_OVF_EN` is defined.

## Operation
- Internal registers:
  - `n_q` (WIDTH): latched operand.
  - `cnt` (WIDTH): current multiplier.
  - `acc` (WIDTH): running product.
  - `ovf_q`: sticky overflow.
- FSM states are IDLE, RUN and DONE.
- IDLE: `busy`=0, `done`=0. On `start`=1, latch `n_q`<=`n`, `acc`<=1, `ovf_q`<=0.
  - If `n`≤1, go to DONE and load `result`<=1.
  - Otherwise set `cnt`<=2 and go to RUN.
- RUN: `busy`=1. Each cycle `acc`<=`acc`×`cnt` and `cnt`<=`cnt`+1.
  - When `cnt`==`n_q`, load `result` with the new product, load `ovf` with the final sticky overflow, and go to DONE.
  - `start` is ignored in RUN.
- DONE: `done`=1 for exactly this cycle, `busy`=0.
  - With `start`=1, behave as IDLE accepting a request (back-to-back operation).
  - With `start`=0, go to IDLE.
- Arithmetic: full product is 2×WIDTH bits.
  - Without `FACT_OVF_EN`: `acc` takes the low WIDTH bits (modulo 2^WIDTH).
  - With `FACT_OVF_EN`: see Configuration.
- Termination is by equality, so `cnt` never passes `n_q` and never wraps. `n`=2^WIDTH−1 is legal.
- `result` and `ovf` change only on entry to DONE. Intermediate products are never visible.

## Timing
- Reset (async, `rst_n`=0): state=IDLE and every register is cleared.
  - Outputs: `busy`=0, `done`=0, `result`=0, `ovf`=0.
  - Reset mid-RUN aborts immediately with the same values. No completion is reported.
- Release of `rst_n` takes effect on the first rising edge after deassertion.
- Latency from the accepting `start` edge to `done` high is max(n,1) cycles:
  - n=0 or 1: 1 cycle.
  - n≥2: n cycles. RUN spans n−1 cycles.
- `busy` rises the cycle after an accepted `start` when n≥2. It falls the same cycle `done` rises.
- Throughput: a new `start` can be accepted in the DONE cycle, giving zero idle cycles between jobs.
- A change on `n` outside the accepting edge has no effect on the current job.

## Configuration
- Macro: `FACT_OVF_EN`.
- Defined:
  - Each RUN step sets `ovf_q` if the upper WIDTH bits of the full product are nonzero.
  - Once `ovf_q` is set, `acc` saturates to all-ones and stays there.
  - On DONE, `result`=2^WIDTH−1 and `ovf`=1 for any overflowed job.
  - `ovf` holds with `result` and clears on the next completion that does not overflow.
- Undefined:
  - No overflow logic is compiled.
  - `ovf` is constant 0 and `result` is n! mod 2^WIDTH.

## Test plan
- WIDTH=8, `n`=5, `start` pulse -> `busy` high 4 cycles, `done` 5 cycles after start, `result`=120, `ovf`=0.
- `n`=0, then `n`=1 -> `done` 1 cycle after each start, `result`=1, `busy` never asserts.
- `n`=6 -> with `FACT_OVF_EN`: `result`=255, `ovf`=1. Without it: `result`=208 (720 mod 256), `ovf`=0.
- `n`=4, then `start` with `n`=3 in the DONE cycle -> `result`=24 with `done`, then `result`=6 with `done` 3 cycles later. A `start` pulse during RUN is ignored and `n` changes mid-RUN have no effect.
- `rst_n` pulled low 2 cycles into an `n`=5 job -> `busy`, `done`, `result` and `ovf` go to 0 asynchronously. After release, `n`=3 gives `result`=6.
- WIDTH=16, `n`=8 -> `result`=40320, `ovf`=0. `n`=9 with `FACT_OVF_EN` -> `result`=65535, `ovf`=1.
